pipe_stage_latch: RTL
=====================

# pipe_stage_latch

Parametrised pipeline stage register that supersedes the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data payload and a separate control bundle between two pipeline stages under a valid/ready handshake. It sits between any two stages of the MIPS pipeline. Beyond a plain enable latch, it adds:

- a two-entry skid buffer, so `in_ready` is a registered signal;
- a synchronous flush that inserts a bubble with zeroed control;
- a saturating stall-cycle counter for performance debug.

## Interface

**Parameters**

- `DATA_W`, default 32: payload width (operands, PC, immediate packed by the instantiating stage).
- `CTRL_W`, default 16: control-bundle width (RegWrite, MemRead, MemWrite, ALUOp, …).
- `CNT_W`, default 16: stall-counter width.

**Ports**

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream stage presents a valid instruction.
- `in_ready`, output, 1: latch can accept this cycle (registered).
- `in_data`, input, `DATA_W`: upstream payload.
- `in_ctrl`, input, `CTRL_W`: upstream control bundle.
- `out_valid`, output, 1: the output entry holds a valid instruction.
- `out_ready`, input, 1: downstream stage consumes this cycle.
- `out_data`, output, `DATA_W`: payload of the head entry.
- `out_ctrl`, output, `CTRL_W`: control of the head entry; all-zero whenever `out_valid`=0.
- `flush`, input, 1: synchronous kill of every held and in-flight entry.
- `clr_stats`, input, 1: synchronous clear of `stall_cnt`.
- `stall_cnt`, output, `CNT_W`: saturating count of stalled cycles.

## Operation

**Transfers**

- Input fire: `in_valid && in_ready`.
- Output fire: `out_valid && out_ready`.

**State machine** (entries held: head register `H`, skid register `S`)

- EMPTY: nothing held.
  - input fire → FULL, `H` ← input.
- FULL: `H` valid.
  - Input fire and output fire → FULL, `H` ← input.
  - Input fire only → SKID, `S` ← input.
  - Output fire only → EMPTY.
  - Neither → hold.
- SKID: `H` and `S` valid; `in_ready`=0, so no input fire is possible.
  - Output fire → FULL, `H` ← `S`.
  - Otherwise hold.

**Derived outputs**

- `in_ready` is registered: it is 1 in the next cycle iff the next state ≠ SKID.
- `out_valid` = (state ≠ EMPTY).
- `out_data`/`out_ctrl` always come from `H`.
- `out_ctrl` is forced to zero when `out_valid`=0, so a bubble never writes registers or memory.

**Flush**

- Next state EMPTY; `H` and `S` control registers are cleared to 0.
- A simultaneous input fire is discarded.
- A simultaneous output fire still completes downstream in that cycle.
- Flush has priority over every transition.
- `in_ready` returns to 1 on the following cycle.

**Stall counter**

- Increments by 1 on every cycle with `out_valid && !out_ready`.
- Saturates at 2^`CNT_W`−1.
- `clr_stats` clears it to 0. If `clr_stats` coincides with a stall cycle, the counter reads 0 (clear wins).
- `flush` does not affect the counter.

**Reset** (asynchronous, `rst_n`=0)

- State EMPTY, `H`/`S` data and control = 0.
- `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0.
- `in_ready`=1. No transfer is recognised while `rst_n`=0.
- Reset mid-transfer loses all held entries; upstream is reset by the same `rst_n`.

## Timing

- Latency: an input fire in cycle N into EMPTY gives `out_valid`=1 with that payload in cycle N+1.
- Throughput: one transfer per cycle in steady state with `out_ready`=1.
- Backpressure: `in_ready` falls one cycle after `out_ready` falls, provided an input fire filled `S`. At most one extra entry is absorbed.
- Ordering: strict FIFO; the `S` contents always leave after `H`.
- Combinational paths: none from `out_ready` to `in_ready`, and none from inputs to `out_*`.

## Structure

- Shared package `pipe_pkg`:
  - state encoding `PS_EMPTY=2'd0`, `PS_FULL=2'd1`, `PS_SKID=2'd2`;
  - default widths;
  - the per-stage `CTRL_W` constants, so every stage instance agrees on bundle layout.
- One natural sub-module: `sat_counter` (parameter `CNT_W`; ports `inc`, `clr`, `count`), reusable for other performance counters.
- The skid FSM and the two entry registers stay in the top module.

## Test plan

1. **Reset.** Drive `rst_n`=0 mid-stream, then release. Required: `out_valid`=0, `out_ctrl`=0, `stall_cnt`=0, `in_ready`=1 on the first cycle after release.
2. **Streaming.** Send `in_data` = 0x1000, 0x1004, 0x1008 on consecutive cycles with `out_ready`=1. Required: outputs appear one cycle later in the same order, with no gaps.
3. **Skid fill.** Hold `out_ready`=0 while sending 0xA and 0xB. Required: `in_ready`=0 from the cycle after 0xB is accepted. On releasing `out_ready`, 0xA then 0xB are output on consecutive cycles and `in_ready` returns to 1.
4. **Flush in SKID.** Hold `H`=0xA, `S`=0xB (`in_ctrl`=0xFFFF) and assert `flush` with a concurrent input. Required: next cycle `out_valid`=0, `out_ctrl`=0; 0xB and the concurrent input never appear.
5. **Stall counter.** With `CNT_W`=4, stall for 20 cycles. Required: `stall_cnt` saturates at 15. A `clr_stats` pulse during a stall cycle gives `stall_cnt`=0 on the next cycle.
6. **Simultaneous events.** In FULL, apply input fire and output fire in the same cycle. Required: state stays FULL, `H` = new payload, `in_ready` stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline latches: state encoding,
// default widths and per-stage control-bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } ps_state_e;

    localparam int PS_DATA_W = 32;
    localparam int PS_CTRL_W = 16;
    localparam int PS_CNT_W  = 16;

    // Every instance of a given stage boundary must agree on its bundle layout.
    localparam int CTRL_W_IF_ID  = 16;
    localparam int CTRL_W_ID_EX  = 16;
    localparam int CTRL_W_EX_MEM = 16;
    localparam int CTRL_W_MEM_WB = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline stage register with a two-entry skid buffer, flush-to-bubble and
// a saturating stall counter.
// Handshake: a transfer occurs on a rising edge where valid && ready; valid
// never depends on ready, and in_ready is a register so no ready path is
// combinational across the stage.
module pipe_stage_latch
    import pipe_pkg::*;
#(
    parameter int DATA_W = PS_DATA_W,
    parameter int CTRL_W = PS_CTRL_W,
    parameter int CNT_W  = PS_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);

    ps_state_e         r_state;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_h_data;
    logic [CTRL_W-1:0] r_h_ctrl;
    logic [DATA_W-1:0] r_s_data;
    logic [CTRL_W-1:0] r_s_ctrl;

    ps_state_e         w_state_nxt;
    logic [DATA_W-1:0] w_h_data_nxt;
    logic [CTRL_W-1:0] w_h_ctrl_nxt;
    logic [DATA_W-1:0] w_s_data_nxt;
    logic [CTRL_W-1:0] w_s_ctrl_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_out_valid;
    logic              w_stall;

    assign w_out_valid = (r_state != PS_EMPTY);
    assign w_in_fire   = in_valid && r_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;
    assign w_stall     = w_out_valid && !out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_h_data_nxt = r_h_data;
        w_h_ctrl_nxt = r_h_ctrl;
        w_s_data_nxt = r_s_data;
        w_s_ctrl_nxt = r_s_ctrl;
        if (flush) begin
            // Any in-flight input is dropped; an output fire this cycle has
            // already been taken by downstream.
            w_state_nxt  = PS_EMPTY;
            w_h_ctrl_nxt = '0;
            w_s_ctrl_nxt = '0;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt  = PS_FULL;
                        w_h_data_nxt = in_data;
                        w_h_ctrl_nxt = in_ctrl;
                    end
                end
                PS_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_h_data_nxt = in_data;
                        w_h_ctrl_nxt = in_ctrl;
                    end else if (w_in_fire) begin
                        w_state_nxt  = PS_SKID;
                        w_s_data_nxt = in_data;
                        w_s_ctrl_nxt = in_ctrl;
                    end else if (w_out_fire) begin
                        w_state_nxt = PS_EMPTY;
                    end
                end
                PS_SKID: begin
                    if (w_out_fire) begin
                        w_state_nxt  = PS_FULL;
                        w_h_data_nxt = r_s_data;
                        w_h_ctrl_nxt = r_s_ctrl;
                    end
                end
                default: begin
                    w_state_nxt = PS_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PS_EMPTY;
            r_in_ready <= 1'b1;
            r_h_data   <= '0;
            r_h_ctrl   <= '0;
            r_s_data   <= '0;
            r_s_ctrl   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != PS_SKID);
            r_h_data   <= w_h_data_nxt;
            r_h_ctrl   <= w_h_ctrl_nxt;
            r_s_data   <= w_s_data_nxt;
            r_s_ctrl   <= w_s_ctrl_nxt;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (w_stall),
        .clr  (clr_stats),
        .count(stall_cnt)
    );

    // Bubbles carry zero control so they can never write registers or memory.
    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_h_data;
    assign out_ctrl  = w_out_valid ? r_h_ctrl : '0;
    assign dbg_state = r_state;

endmodule
